// File: rtl/fir_stream_pkg.sv
// fir_stream_pkg: FSM state encodings and width helpers shared by the sample source blocks
package fir_stream_pkg;
  typedef enum logic {S_IDLE = 1'b0, S_VALID = 1'b1} state_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: circular sample buffer with a registered read on pop
//   clk, rst        clock, synchronous active-high reset
//   wr_en, wr_data  write strobe and word; dropped while full
//   pop             advance the head into rd_data (next cycle); ignored while empty
//   rd_data         last popped word
//   count/full/empty occupancy and its flags, combinational from the count
module sample_fifo
  import fir_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 16,
  localparam int PW = ptr_w(FIFO_DEPTH),
  localparam int CW = cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic wr_ok, pop_ok;
  assign full = count_q == CW'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign rd_data = rd_data_q;
  // Full/empty come from the pre-cycle count, so a write while full is lost even with a pop.
  always_comb begin
    wr_ok = wr_en && !full;
    pop_ok = pop && !empty;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = (wr_ok && !pop_ok) ? count_q + 1'b1 : (pop_ok && !wr_ok) ? count_q - 1'b1 : count_q;
    rd_data_d = pop_ok ? mem[rd_ptr_q] : rd_data_q;
  end
  always_ff @(posedge clk) if (wr_ok) mem[wr_ptr_q] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      rd_data_q <= rd_data_d;
    end
  end
endmodule

// File: rtl/fir_sample_source.sv
// fir_sample_source: buffers upstream samples and presents one per sample tick to the FIR input
//   i_clk, i_rst, i_en           clock, synchronous active-high reset, enable (freezes ticks and FSM)
//   iv_wr_data, i_wr_en          upstream sample write
//   o_full, o_empty, ov_count    buffer status
//   ov_dout, o_dout_valid        presented sample, held until i_ready
//   i_clr_flags                  clears o_overflow, o_underrun, o_late (set events win)
module fir_sample_source
  import fir_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_PERIOD = 64,
  localparam int CW = cnt_w(FIFO_DEPTH),
  localparam int TW = SAMPLE_PERIOD > 1 ? $clog2(SAMPLE_PERIOD) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] iv_wr_data,
  input  logic                  i_wr_en,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CW-1:0]         ov_count,
  output logic [DATA_WIDTH-1:0] ov_dout,
  output logic                  o_dout_valid,
  input  logic                  i_ready,
  input  logic                  i_clr_flags,
  output logic                  o_overflow,
  output logic                  o_underrun,
  output logic                  o_late
);
  state_t state_q, state_d;
  logic [TW-1:0] per_q, per_d;
  logic ovf_q, ovf_d, und_q, und_d, late_q, late_d;
  logic tick, pop;
  sample_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk), .rst(i_rst), .wr_en(i_wr_en), .wr_data(iv_wr_data), .pop(pop),
    .rd_data(ov_dout), .count(ov_count), .full(o_full), .empty(o_empty)
  );
  // A tick arriving while a sample is still presented is not queued: it either flags late or is lost.
  always_comb begin
    tick = i_en && per_q == TW'(SAMPLE_PERIOD - 1);
    per_d = !i_en ? per_q : tick ? '0 : per_q + 1'b1;
    pop = tick && state_q == S_IDLE && !o_empty;
    state_d = !i_en ? state_q : pop ? S_VALID : (state_q == S_VALID && i_ready) ? S_IDLE : state_q;
    ovf_d = (i_wr_en && o_full) || (ovf_q && !i_clr_flags);
    und_d = (tick && state_q == S_IDLE && o_empty) || (und_q && !i_clr_flags);
    late_d = (tick && state_q == S_VALID && !i_ready) || (late_q && !i_clr_flags);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      per_q <= '0;
      ovf_q <= 1'b0;
      und_q <= 1'b0;
      late_q <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q <= per_d;
      ovf_q <= ovf_d;
      und_q <= und_d;
      late_q <= late_d;
    end
  end
  assign o_dout_valid = state_q == S_VALID;
  assign o_overflow = ovf_q;
  assign o_underrun = und_q;
  assign o_late = late_q;
endmodule
